// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the clock time-set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [1:0] ED_IDLE   = 2'b00;
    localparam logic [1:0] ED_HR     = 2'b01;
    localparam logic [1:0] ED_MIN    = 2'b10;
    localparam logic [1:0] ED_COMMIT = 2'b11;

    localparam logic [3:0] HR_MAX_MS         = 4'd2;
    localparam logic [3:0] HR_MAX_LS_AT_MAX  = 4'd3;
    localparam logic [3:0] MIN_MAX_MS        = 4'd5;
    localparam logic [3:0] MIN_MAX_LS_AT_MAX = 4'd9;
    localparam logic [3:0] BCD_MAX           = 4'd9;

endpackage

// File: rtl/bcd_field_stepper.sv
// Next-value logic for a two-digit BCD field: up/down wrap plus
// clamping of an out-of-range field to 00.
module bcd_field_stepper
    import clock_pkg::*;
#(
    parameter logic [3:0] MAX_MS        = 4'd2,
    parameter logic [3:0] MAX_LS_AT_MAX = 4'd3
) (
    input  logic [3:0] ms,
    input  logic [3:0] ls,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] nx_ms,
    output logic [3:0] nx_ls
);

    logic invalid;
    logic at_max;
    logic at_zero;

    assign invalid = (ms > MAX_MS) || (ls > BCD_MAX) ||
                     ((ms == MAX_MS) && (ls > MAX_LS_AT_MAX));
    assign at_max  = (ms == MAX_MS) && (ls == MAX_LS_AT_MAX);
    assign at_zero = (ms == 4'd0) && (ls == 4'd0);

    always_comb begin
        nx_ms = ms;
        nx_ls = ls;
        if (invalid) begin
            nx_ms = 4'd0;
            nx_ls = 4'd0;
        end else if (inc && !dec) begin
            if (at_max) begin
                nx_ms = 4'd0;
                nx_ls = 4'd0;
            end else if (ls == BCD_MAX) begin
                nx_ms = ms + 4'd1;
                nx_ls = 4'd0;
            end else begin
                nx_ls = ls + 4'd1;
            end
        end else if (dec && !inc) begin
            if (at_zero) begin
                nx_ms = MAX_MS;
                nx_ls = MAX_LS_AT_MAX;
            end else if (ls == 4'd0) begin
                nx_ms = ms - 4'd1;
                nx_ls = BCD_MAX;
            end else begin
                nx_ls = ls - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_time_setter.sv
// Button-driven hours/minutes editor that commits a shadow time to the
// BCD clock with a one-cycle load strobe, abandoning idle edits.
module clock_time_setter
    import clock_pkg::*;
#(
    parameter int SET_TIMEOUT = 30,
    parameter int TMO_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_ms_hr,
    input  logic [3:0] cur_ls_hr,
    input  logic [3:0] cur_ms_min,
    input  logic [3:0] cur_ls_min,
    output logic       load,
    output logic [3:0] load_ms_hr,
    output logic [3:0] load_ls_hr,
    output logic [3:0] load_ms_min,
    output logic [3:0] load_ls_min,
    output logic [1:0] editing
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SET_TIMEOUT - 1);

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       prev;
    logic             mode_e, inc_e, dec_e, step_e, tmo_hit;
    logic             capture;

    logic [3:0] sh_ms_hr, sh_ls_hr, sh_ms_min, sh_ls_min;
    logic [3:0] hr_ms_in, hr_ls_in, min_ms_in, min_ls_in;
    logic [3:0] hr_ms_nx, hr_ls_nx, min_ms_nx, min_ls_nx;

    assign mode_e  = btn_mode & ~prev[2];
    assign inc_e   = btn_inc  & ~prev[1];
    assign dec_e   = btn_dec  & ~prev[0];
    assign step_e  = inc_e | dec_e;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // In IDLE the steppers see the live time with no step, so their
    // output is the validated snapshot.
    assign capture   = (state == IDLE);
    assign hr_ms_in  = capture ? cur_ms_hr  : sh_ms_hr;
    assign hr_ls_in  = capture ? cur_ls_hr  : sh_ls_hr;
    assign min_ms_in = capture ? cur_ms_min : sh_ms_min;
    assign min_ls_in = capture ? cur_ls_min : sh_ls_min;

    bcd_field_stepper #(
        .MAX_MS        (HR_MAX_MS),
        .MAX_LS_AT_MAX (HR_MAX_LS_AT_MAX)
    ) u_hr (
        .ms    (hr_ms_in),
        .ls    (hr_ls_in),
        .inc   ((state == SET_HR) & inc_e),
        .dec   ((state == SET_HR) & dec_e),
        .nx_ms (hr_ms_nx),
        .nx_ls (hr_ls_nx)
    );

    bcd_field_stepper #(
        .MAX_MS        (MIN_MAX_MS),
        .MAX_LS_AT_MAX (MIN_MAX_LS_AT_MAX)
    ) u_min (
        .ms    (min_ms_in),
        .ls    (min_ls_in),
        .inc   ((state == SET_MIN) & inc_e),
        .dec   ((state == SET_MIN) & dec_e),
        .nx_ms (min_ms_nx),
        .nx_ls (min_ls_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load      <= 1'b0;
            editing   <= ED_IDLE;
            tmo_cnt   <= '0;
            prev      <= 3'b111;
            sh_ms_hr  <= 4'd0;
            sh_ls_hr  <= 4'd0;
            sh_ms_min <= 4'd0;
            sh_ls_min <= 4'd0;
        end else begin
            prev <= {btn_mode, btn_inc, btn_dec};
            load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mode_e) begin
                        sh_ms_hr  <= hr_ms_nx;
                        sh_ls_hr  <= hr_ls_nx;
                        sh_ms_min <= min_ms_nx;
                        sh_ls_min <= min_ls_nx;
                        state     <= SET_HR;
                        editing   <= ED_HR;
                        tmo_cnt   <= '0;
                    end
                end
                SET_HR: begin
                    if (mode_e) begin
                        state   <= SET_MIN;
                        editing <= ED_MIN;
                        tmo_cnt <= '0;
                    end else if (step_e) begin
                        sh_ms_hr <= hr_ms_nx;
                        sh_ls_hr <= hr_ls_nx;
                        tmo_cnt  <= '0;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        editing <= ED_IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SET_MIN: begin
                    if (mode_e) begin
                        state   <= COMMIT;
                        editing <= ED_COMMIT;
                        load    <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (step_e) begin
                        sh_ms_min <= min_ms_nx;
                        sh_ls_min <= min_ls_nx;
                        tmo_cnt   <= '0;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        editing <= ED_IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state   <= IDLE;
                    editing <= ED_IDLE;
                end
                default: begin
                    state   <= IDLE;
                    editing <= ED_IDLE;
                end
            endcase
        end
    end

    assign load_ms_hr  = sh_ms_hr;
    assign load_ls_hr  = sh_ls_hr;
    assign load_ms_min = sh_ms_min;
    assign load_ls_min = sh_ls_min;

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed scoreboard bench for the clock time-set controller.
module tb_clock_time_setter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_inc, btn_dec;
    logic [15:0] cur;
    logic       load;
    logic [3:0] load_ms_hr, load_ls_hr, load_ms_min, load_ls_min;
    logic [1:0] editing;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        ld;
        logic [1:0]  ed;
        logic [15:0] dg;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clock_time_setter #(.SET_TIMEOUT(30), .TMO_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .cur_ms_hr   (cur[15:12]),
        .cur_ls_hr   (cur[11:8]),
        .cur_ms_min  (cur[7:4]),
        .cur_ls_min  (cur[3:0]),
        .load        (load),
        .load_ms_hr  (load_ms_hr),
        .load_ls_hr  (load_ls_hr),
        .load_ms_min (load_ms_min),
        .load_ls_min (load_ls_min),
        .editing     (editing)
    );

    task automatic step(input logic m, input logic i, input logic d,
                        input logic el, input logic [1:0] ee,
                        input logic [15:0] edg, input string tag);
        exp_t e;
        logic [18:0] got;
        logic [18:0] want;
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        sb.push_back('{el, ee, edg, tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got  = {load, editing, load_ms_hr, load_ls_hr,
                load_ms_min, load_ls_min};
        want = {e.ld, e.ed, e.dg};
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got load=%b ed=%b t=%h, exp load=%b ed=%b t=%h",
                   e.tag, got[18], got[17:16], got[15:0],
                   want[18], want[17:16], want[15:0]);
        end
    endtask

    initial begin
        rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
        cur = 16'h0000;
        step(1, 0, 0, 0, 2'b00, 16'h0000, "reset_a");
        step(1, 0, 0, 0, 2'b00, 16'h0000, "reset_b");
        rst = 1'b0;

        // button held through reset gives no edge
        step(1, 0, 0, 0, 2'b00, 16'h0000, "held_thru_rst");
        step(0, 0, 0, 0, 2'b00, 16'h0000, "release");
        step(1, 0, 0, 0, 2'b01, 16'h0000, "first_press");
        step(0, 0, 0, 0, 2'b01, 16'h0000, "rel1");
        step(1, 0, 0, 0, 2'b10, 16'h0000, "to_min");
        step(0, 0, 0, 0, 2'b10, 16'h0000, "rel2");
        step(1, 0, 0, 1, 2'b11, 16'h0000, "commit0");
        step(0, 0, 0, 0, 2'b00, 16'h0000, "idle0");

        // 12:34 -> 14:33
        cur = 16'h1234;
        step(0, 1, 0, 0, 2'b00, 16'h0000, "idle_inc_ignored");
        step(0, 0, 0, 0, 2'b00, 16'h0000, "idle_rel");
        step(1, 0, 0, 0, 2'b01, 16'h1234, "cap_1234");
        step(0, 0, 0, 0, 2'b01, 16'h1234, "r");
        step(0, 1, 0, 0, 2'b01, 16'h1334, "hr_inc1");
        step(0, 0, 0, 0, 2'b01, 16'h1334, "r");
        step(0, 1, 0, 0, 2'b01, 16'h1434, "hr_inc2");
        step(0, 0, 0, 0, 2'b01, 16'h1434, "r");
        step(1, 0, 0, 0, 2'b10, 16'h1434, "to_min");
        step(0, 0, 0, 0, 2'b10, 16'h1434, "r");
        step(0, 0, 1, 0, 2'b10, 16'h1433, "min_dec");
        step(0, 0, 0, 0, 2'b10, 16'h1433, "r");
        step(1, 0, 0, 1, 2'b11, 16'h1433, "commit_1433");
        step(0, 0, 0, 0, 2'b00, 16'h1433, "idle_1433");

        // 23:59 wraps up to 00:00
        cur = 16'h2359;
        step(1, 0, 0, 0, 2'b01, 16'h2359, "cap_2359");
        step(0, 1, 0, 0, 2'b01, 16'h0059, "hr_wrap_up");
        step(1, 0, 0, 0, 2'b10, 16'h0059, "to_min");
        step(0, 1, 0, 0, 2'b10, 16'h0000, "min_wrap_up");
        step(1, 0, 0, 1, 2'b11, 16'h0000, "commit_0000");
        step(0, 0, 0, 0, 2'b00, 16'h0000, "idle");

        // 00:00 wraps down to 23:59
        cur = 16'h0000;
        step(1, 0, 0, 0, 2'b01, 16'h0000, "cap_0000");
        step(0, 0, 1, 0, 2'b01, 16'h2300, "hr_wrap_dn");
        step(1, 0, 0, 0, 2'b10, 16'h2300, "to_min");
        step(0, 0, 1, 0, 2'b10, 16'h2359, "min_wrap_dn");
        step(1, 0, 0, 1, 2'b11, 16'h2359, "commit_2359");
        step(0, 0, 0, 0, 2'b00, 16'h2359, "idle");

        // digit carries 19->20, 09->10, 10->09
        cur = 16'h1909;
        step(1, 0, 0, 0, 2'b01, 16'h1909, "cap_1909");
        step(0, 1, 0, 0, 2'b01, 16'h2009, "hr_19_20");
        step(0, 0, 0, 0, 2'b01, 16'h2009, "r");
        step(0, 0, 1, 0, 2'b01, 16'h1909, "hr_20_19");
        step(1, 0, 0, 0, 2'b10, 16'h1909, "to_min");
        step(0, 1, 0, 0, 2'b10, 16'h1910, "min_09_10");
        step(0, 0, 0, 0, 2'b10, 16'h1910, "r");
        step(0, 0, 1, 0, 2'b10, 16'h1909, "min_10_09");
        step(1, 0, 0, 1, 2'b11, 16'h1909, "commit_1909");
        step(0, 0, 0, 0, 2'b00, 16'h1909, "idle");

        // invalid snapshots clamp per field
        cur = 16'h276A;
        step(1, 0, 0, 0, 2'b01, 16'h0000, "cap_276a");
        step(1, 0, 0, 0, 2'b01, 16'h0000, "held_no_edge");
        step(0, 0, 0, 0, 2'b01, 16'h0000, "r");
        step(1, 0, 0, 0, 2'b10, 16'h0000, "to_min");
        step(0, 0, 0, 0, 2'b10, 16'h0000, "r");
        step(1, 0, 0, 1, 2'b11, 16'h0000, "commit_inv");
        step(0, 0, 0, 0, 2'b00, 16'h0000, "idle");
        cur = 16'h2545;
        step(1, 0, 0, 0, 2'b01, 16'h0045, "cap_2545");
        step(0, 0, 0, 0, 2'b01, 16'h0045, "r");
        step(1, 0, 0, 0, 2'b10, 16'h0045, "to_min");
        step(0, 0, 0, 0, 2'b10, 16'h0045, "r");
        step(1, 0, 0, 1, 2'b11, 16'h0045, "commit_0045");
        step(0, 0, 0, 0, 2'b00, 16'h0045, "idle");
        cur = 16'h1260;
        step(1, 0, 0, 0, 2'b01, 16'h1200, "cap_1260");
        step(0, 0, 0, 0, 2'b01, 16'h1200, "r");

        // priority: mode beats inc, inc+dec together is a no-op
        step(0, 1, 1, 0, 2'b01, 16'h1200, "inc_dec_both");
        step(0, 0, 0, 0, 2'b01, 16'h1200, "r");
        step(1, 1, 0, 0, 2'b10, 16'h1200, "mode_beats_inc");
        step(0, 0, 0, 0, 2'b10, 16'h1200, "r");
        step(0, 1, 1, 0, 2'b10, 16'h1200, "min_inc_dec_both");
        step(0, 0, 0, 0, 2'b10, 16'h1200, "r");
        step(1, 0, 0, 1, 2'b11, 16'h1200, "commit_1200");
        step(0, 0, 0, 0, 2'b00, 16'h1200, "idle");

        // timeout in SET_MIN after 30 idle cycles
        cur = 16'h1111;
        step(1, 0, 0, 0, 2'b01, 16'h1111, "cap_1111");
        step(0, 0, 0, 0, 2'b01, 16'h1111, "r");
        step(1, 0, 0, 0, 2'b10, 16'h1111, "to_min");
        for (int n = 1; n <= 30; n++)
            step(0, 0, 0, 0, (n < 30) ? 2'b10 : 2'b00, 16'h1111,
                 (n < 30) ? "tmo_wait" : "tmo_idle");
        step(0, 0, 0, 0, 2'b00, 16'h1111, "tmo_stay_idle");

        // inc at cycle 29 restarts the timeout
        step(1, 0, 0, 0, 2'b01, 16'h1111, "cap_again");
        step(0, 0, 0, 0, 2'b01, 16'h1111, "r");
        step(1, 0, 0, 0, 2'b10, 16'h1111, "to_min");
        for (int n = 1; n <= 40; n++) begin
            if (n < 29)
                step(0, 0, 0, 0, 2'b10, 16'h1111, "pre_inc");
            else if (n == 29)
                step(0, 1, 0, 0, 2'b10, 16'h1112, "inc_29");
            else
                step(0, 0, 0, 0, 2'b10, 16'h1112, "still_edit");
        end

        // reset mid-edit clears everything without a load
        rst = 1'b1;
        step(0, 0, 0, 0, 2'b00, 16'h0000, "rst_mid_edit");
        rst = 1'b0;
        step(0, 0, 0, 0, 2'b00, 16'h0000, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
